decoder_scan_seq: RTL

Parametrised, registered successor to the team's fixed combinational 3-to-8 decoder. Drives a one-hot select bus (register/bank/line select) from SEL_W input bits. Two operations:
- Load: decode one select value and hold it.
- Scan: walk the one-hot bit up or down for a programmed number of cycles, with wrap and done indications.
Used by the datapath and test logic wherever a sequenced one-hot select is needed.

---
 rtl/decoder_scan_seq_pkg.sv | 12 +
 rtl/decoder_scan_seq_if.sv | 32 +++
 rtl/decoder_scan_seq_dec.sv | 15 +
 rtl/decoder_scan_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/decoder_scan_seq_pkg.sv
// Shared types and constants for the one-hot select sequencer.
package decoder_scan_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control/result bundle between a select-sequencer user and decoder_scan_seq.
interface decoder_scan_seq_if #(
  parameter int SEL_W = 3
);
  import decoder_scan_seq_pkg::*;

  localparam int OUT_W = 2**SEL_W;

  logic               load;
  logic               start;
  logic               abort;
  logic               dir;
  logic [SEL_W-1:0]   sel_in;
  logic [SEL_W:0]     len_in;
  logic [OUT_W-1:0]   onehot_out;
  logic [SEL_W-1:0]   sel_out;
  logic               valid;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
    output load, start, abort, dir, sel_in, len_in,
    input  onehot_out, sel_out, valid, busy, wrap, done
  );

  modport slave (
    input  load, start, abort, dir, sel_in, len_in,
    output onehot_out, sel_out, valid, busy, wrap, done
  );

endinterface

// File: rtl/decoder_scan_seq_dec.sv
// Combinational SEL_W-to-2**SEL_W decoder with enable; all-zero when disabled.
module dec_n_to_onehot #(
  parameter int SEL_W = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered one-hot select: load-and-hold or up/down scan with wrap/done pulses.
module decoder_scan_seq
  import decoder_scan_seq_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input logic               clk,
  input logic               rst,
  decoder_scan_seq_if.slave bus
);

  localparam int CNT_W = SEL_W + 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [(2**SEL_W)-1:0] onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.abort) begin
          sel_d   = '0;
          valid_d = 1'b0;
        end else if (bus.start && (bus.len_in != '0)) begin
          // First step shows sel_in itself, so len_in-1 further steps remain.
          dir_d   = bus.dir;
          sel_d   = bus.sel_in;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = bus.len_in - CNT_W'(1);
          state_d = SCAN;
        end else if (bus.load) begin
          sel_d   = bus.sel_in;
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (bus.abort || (cnt_q == '0)) begin
          sel_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          done_d  = ~bus.abort;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (dir_q == DIR_UP) begin
            sel_d  = sel_q + SEL_W'(1);
            wrap_d = (sel_q == '1);
          end else begin
            sel_d  = sel_q - SEL_W'(1);
            wrap_d = (sel_q == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dec_n_to_onehot #(.SEL_W(SEL_W)) u_dec (
    .en     (valid_q),
    .sel    (sel_q),
    .onehot (onehot)
  );

  assign bus.onehot_out = onehot;
  assign bus.sel_out    = sel_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.wrap       = wrap_q;
  assign bus.done       = done_q;

endmodule
